muldiv_unit: RTL and testbench

- Iterative, parametrised multiply/divide unit covering the full RV32M set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Successor to the single-cycle ALU multiply path: it adds divide/remainder, radix-2 multi-cycle operation, and a valid/ready handshake.
- Sits beside the ALU in EX. The pipeline stalls on `in_ready`/`out_valid` and drops an in-flight operation with `flush`.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_sign_prep.sv | 40 ++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state enums and op-decoding helpers for the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response handshake bundle between the pipeline and the multiply/divide unit
interface muldiv_if #(parameter int XLEN = 32);
  import muldiv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  muldiv_op_e      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;
  logic            flush;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready, flush,
    output in_ready, out_valid, out_result, busy
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready, flush,
    input  in_ready, out_valid, out_result, busy
  );

endinterface

// File: rtl/muldiv_sign_prep.sv
// rtl/muldiv_sign_prep.sv - operand magnitudes, result signs and divide special-case detection
module muldiv_sign_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_e      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_q,
  output logic            neg_r,
  output logic            special,
  output logic [XLEN-1:0] special_result
);

  logic sign_a;
  logic sign_b;
  logic div_zero;
  logic overflow;

  always_comb begin
    sign_a = is_signed_a(op) && a[XLEN-1];
    sign_b = is_signed_b(op) && b[XLEN-1];
    // One extra bit so the most-negative value negates to its true magnitude.
    mag_a = XLEN'(({sign_a, a} ^ {(XLEN+1){sign_a}}) + (XLEN+1)'(sign_a));
    mag_b = XLEN'(({sign_b, b} ^ {(XLEN+1){sign_b}}) + (XLEN+1)'(sign_b));
    neg_q = sign_a ^ sign_b;
    neg_r = sign_a;

    div_zero = is_div(op) && (b == '0);
    overflow = (op inside {OP_DIV, OP_REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = div_zero || overflow;

    if (div_zero) special_result = is_rem(op) ? a : '1;
    else          special_result = is_rem(op) ? '0 : a;
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit with valid/ready handshake and flush
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(XLEN + 1);

  muldiv_state_e   state, state_n;
  muldiv_op_e      op_q;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] dvs;
  logic            neg_q_q;
  logic            neg_r_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] p_mag_a, p_mag_b, p_special_result;
  logic            p_neg_q, p_neg_r, p_special;

  logic              accept;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_result;

  muldiv_sign_prep #(.XLEN(XLEN)) u_prep (
    .op             (bus.in_op),
    .a              (bus.in_a),
    .b              (bus.in_b),
    .mag_a          (p_mag_a),
    .mag_b          (p_mag_b),
    .neg_q          (p_neg_q),
    .neg_r          (p_neg_r),
    .special        (p_special),
    .special_result (p_special_result)
  );

  assign accept = bus.in_valid && (state == IDLE) && !bus.flush;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = p_special ? DONE : CALC;
      CALC:    if (count == '0) state_n = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    div_shift = {hi, lo[XLEN-1]};
    // Partial remainder stays below the divisor, so the difference fits signed XLEN+1 bits.
    div_diff  = div_shift - {1'b0, dvs};
    div_ge    = !div_diff[XLEN];

    prod_raw = {hi, lo};
    prod     = neg_q_q ? -prod_raw : prod_raw;
    quo      = neg_q_q ? -lo : lo;
    rem      = neg_r_q ? -hi : hi;

    unique case (op_q)
      OP_MUL:                        final_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_result = quo;
      default:                       final_result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_MUL;
      count       <= '0;
      hi          <= '0;
      lo          <= '0;
      dvs         <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != IDLE);
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            op_q    <= bus.in_op;
            neg_q_q <= p_neg_q;
            neg_r_q <= p_neg_r;
            count   <= CW'(XLEN);
            hi      <= '0;
            // lo holds the multiplier or the dividend; dvs the multiplicand or the divisor.
            lo      <= is_div(bus.in_op) ? p_mag_a : p_mag_b;
            dvs     <= is_div(bus.in_op) ? p_mag_b : p_mag_a;
            if (p_special) result_q <= p_special_result;
          end
          CALC: begin
            if (count == '0) begin
              result_q    <= final_result;
              out_valid_q <= 1'b1;
            end else begin
              count <= count - CW'(1);
              if (is_div(op_q)) begin
                hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                lo <= {lo[XLEN-2:0], div_ge};
              end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
              end
            end
          end
          DONE: begin
            if (!out_valid_q)        out_valid_q <= 1'b1;
            else if (bus.out_ready)  out_valid_q <= 1'b0;
          end
          default: out_valid_q <= 1'b0;
        endcase
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q;
    longint unsigned ua, ub, uq;
    logic [63:0]     p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin p = ua * ub;          return p[31:0];  end
      3'd1: begin p = sa * sb;          return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;          return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; uq = ua / ub; return uq[31:0]; end
      3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default: begin if (b == 0) return a; uq = ua % ub; return uq[31:0]; end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          cyc;
    logic [31:0] exp;
    logic [31:0] first;
    exp = model(op, a, b);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_op     = muldiv_op_e'(op);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check($sformatf("latency op%0d", op), 64'(cyc), 64'(latency(op, a, b)));
    check($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(bus.out_result), 64'(exp));
    first = bus.out_result;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_stable", 64'(bus.out_result), 64'(first));
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("handshake_valid_drop", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          seen;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    tick();

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    check("mul_directed", 64'(bus.out_result), 64'h0000_0000_FFFF_FFEB);
    run_op(3'd1, MIN, MIN, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mulhu_directed", 64'(bus.out_result), 64'h0000_0000_FFFF_FFFE);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    check("rem_directed", 64'(bus.out_result), 64'h0000_0000_FFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 0);
    check("divu_directed", 64'(bus.out_result), 64'd14);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd4, 32'd5, 32'd0, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    check("remu_div0_directed", 64'(bus.out_result), 64'd5);
    run_op(3'd4, MIN, 32'hFFFF_FFFF, 0);
    run_op(3'd6, MIN, 32'hFFFF_FFFF, 0);

    run_op(3'd5, 32'd1000, 32'd9, 5);
    run_op(3'd1, 32'h1234_5678, 32'h8765_4321, 3);

    bus.in_valid = 1'b1;
    bus.in_op    = OP_DIVU;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    bus.in_a     = 32'd3;
    bus.in_b     = 32'd4;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid || !bus.in_ready || bus.busy) seen++;
    end
    check("flush_quiet", 64'(seen), 64'd0);

    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_DIVU;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_rst_out_result", 64'(bus.out_result), 64'd0);
    check("abort_rst_busy", 64'(bus.busy), 64'd0);
    check("abort_rst_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("abort_rst_quiet", 64'(seen), 64'd0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = MIN; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = MIN;
        default: ;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
